rising_edge_detector: RTL and testbench

//   Converts a slow level input into a tick that marks each 0->1 transition.
//   One source file holds both FSM styles, selected by parameter:
//   - Mealy: combinational tick, zero latency.
//   - Moore: registered-state tick, one-cycle latency.

---
 rtl/rising_edge_detector.sv | 37 +++
 tb/tb_rising_edge_detector.sv | 83 ++++++++
 2 files changed

// File: rtl/rising_edge_detector.sv
// rising_edge_detector: one tick per 0->1 transition of level, Mealy (STYLE=0) or Moore (STYLE=1)
module rising_edge_detector #(
  parameter int STYLE = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic tick
);
  typedef enum logic [1:0] {ZERO, EDGE, ONE} state_t;
  state_t state, next;
  logic   raw;
  if (STYLE != 0 && STYLE != 1) begin : g_bad_style
    $error("rising_edge_detector: STYLE must be 0 (Mealy) or 1 (Moore)");
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ZERO;
    else state <= next;
  // EDGE only exists in the Moore machine; in Mealy it falls to the recovery default
  always_comb begin
    next = ZERO;
    raw  = 1'b0;
    case (state)
      ZERO: begin
        next = level ? ((STYLE == 1) ? EDGE : ONE) : ZERO;
        raw  = (STYLE == 0) && level;
      end
      EDGE: begin
        next = (STYLE == 1 && level) ? ONE : ZERO;
        raw  = (STYLE == 1);
      end
      ONE:     next = level ? ONE : ZERO;
      default: next = ZERO;
    endcase
  end
  assign tick = raw && !reset;
endmodule

// File: tb/tb_rising_edge_detector.sv
// tb_rising_edge_detector: scoreboard bench running Mealy and Moore instances side by side
module tb_rising_edge_detector;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic level = 1'b0;
  logic tick_mealy, tick_moore;
  int total = 0;
  int passed = 0;
  logic [1:0] exp_q[$];
  logic last = 1'b0;
  logic mtick = 1'b0;
  logic [1:0] e;
  always #5 clk = ~clk;
  rising_edge_detector #(.STYLE(0)) u_mealy (.clk(clk), .reset(reset), .level(level), .tick(tick_mealy));
  rising_edge_detector #(.STYLE(1)) u_moore (.clk(clk), .reset(reset), .level(level), .tick(tick_moore));
  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: tick=%b, required %b at t=%0t", tag, obs, exp, $time);
  endtask
  task automatic compare(input string tag);
    e = exp_q.pop_front();
    check({tag, "/mealy"}, tick_mealy, e[1]);
    check({tag, "/moore"}, tick_moore, e[0]);
  endtask
  // model: Mealy ticks while level is high and the last sample was low;
  // Moore ticks for the cycle after a sample of 1 that followed a sample of 0
  task automatic step(input logic r, input logic lv, input string tag);
    @(posedge clk);
    if (reset) begin
      mtick = 1'b0;
      last  = 1'b0;
    end else begin
      mtick = level & ~last;
      last  = level;
    end
    #2;
    reset = r;
    level = lv;
    if (r) begin
      mtick = 1'b0;
      last  = 1'b0;
    end
    exp_q.push_back({~r & lv & ~last, ~r & mtick});
    #4;
    compare(tag);
  endtask
  initial begin
    for (int i = 0; i < 20; i++) step(1'b1, 1'((i / 5) % 2), "reset_hold");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "idle");
    step(1'b0, 1'b1, "rise");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "hold5");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "fall");
    step(1'b0, 1'b1, "rise2");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, "hold10");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "fall2");
    step(1'b0, 1'b1, "pulse");
    step(1'b0, 1'b0, "pulse_end");
    step(1'b0, 1'b0, "pulse_idle");
    step(1'b0, 1'b1, "after_pulse");
    step(1'b0, 1'b1, "after_pulse_hold");
    step(1'b0, 1'b0, "after_pulse_fall");
    step(1'b0, 1'b0, "idle2");
    step(1'b0, 1'b1, "pre_edge");
    step(1'b0, 1'b1, "in_edge");
    #1;
    reset = 1'b1;
    mtick = 1'b0;
    last  = 1'b0;
    exp_q.push_back(2'b00);
    #1;
    compare("reset_mid_edge");
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, "reset_low");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "release_low");
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, "reset_high");
    step(1'b0, 1'b1, "release_high");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "release_hold");
    step(1'b0, 1'b0, "release_fall");
    for (int i = 0; i < 60; i++) step(1'b0, 1'($urandom_range(0, 1)), "random");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
